// File: rtl/parity_frame_receiver_pkg.sv
// Shared definitions for the parity-protected byte link (receiver and serializer).
package parity_frame_receiver_pkg;

    // Frame position tracked by both ends of the link.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } link_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Parity mismatch: accumulated data XOR, received parity bit, and odd/even selection.
    function automatic logic parity_mismatch(logic acc, logic par_bit, logic odd);
        return acc ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_receiver_if.sv
// Valid/ready stream of checked bytes leaving the receiver.
interface parity_frame_receiver_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_parity_err;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_parity_err,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_parity_err,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/parity_rx_out_buffer.sv
// Single-entry output buffer: holds one checked frame until the consumer takes it.
// A push is accepted when empty, or when full and the consumer pops in the same cycle.
module parity_rx_out_buffer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_err_i,
    output logic                  can_push_c_o,
    parity_frame_receiver_if.master out_if
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    assign can_push_c_o = ~valid_q | out_if.out_ready;

    // Load on accepted push, otherwise empty on handshake; contents never overwritten while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (push_i && can_push_c_o) begin
            valid_q <= 1'b1;
            data_q  <= push_data_i;
            err_q   <= push_err_i;
        end else if (out_if.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_if.out_valid      = valid_q;
    assign out_if.out_data       = data_q;
    assign out_if.out_parity_err = err_q;

endmodule

// File: rtl/parity_frame_receiver.sv
// Receive end of the parity-protected byte link: deframes serial bits, checks parity,
// hands bytes to a valid/ready consumer and counts parity-error frames.
module parity_frame_receiver
    import parity_frame_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter bit          ODD_PARITY    = 1'b0,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_bit,
    input  logic                     in_bit_valid,
    input  logic                     clr_count,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    parity_frame_receiver_if.master  out_if
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]         LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;

    link_state_e             state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    acc_q;
    logic                    par_err_q;
    logic                    frame_err_q;
    logic                    overflow_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    logic push_c;
    logic can_push_c;
    logic loaded_c;

    assign push_c   = (state_q == STOP) && in_bit_valid && (in_bit == STOP_BIT);
    assign loaded_c = push_c && can_push_c;

    // Frame FSM with shift register, bit counter, parity accumulator and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            acc_q       <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            if (in_bit_valid) begin
                case (state_q)
                    IDLE: begin
                        if (in_bit == START_BIT) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                            acc_q     <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_q <= {in_bit, shift_q[DATA_WIDTH-1:1]};
                        acc_q   <= acc_q ^ in_bit;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        par_err_q <= parity_mismatch(acc_q, in_bit, ODD_PARITY);
                        state_q   <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (in_bit != STOP_BIT) begin
                            frame_err_q <= 1'b1;
                        end else if (!can_push_c) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Saturating count of parity-error frames entering the buffer; clear wins.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            err_cnt_q <= '0;
        end else if (loaded_c && par_err_q && (err_cnt_q != ERR_MAX)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    parity_rx_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buffer (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_c),
        .push_data_i  (shift_q),
        .push_err_i   (par_err_q),
        .can_push_c_o (can_push_c),
        .out_if       (out_if)
    );

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Self-checking bench for parity_frame_receiver: directed frames plus randomized gapped traffic
// compared against a queue-based model of delivered bytes and an error-count model.
module tb_parity_frame_receiver;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_bit;
    logic          in_bit_valid;
    logic          clr_count;
    logic          frame_err;
    logic          overflow;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    parity_frame_receiver_if #(.DATA_WIDTH(DW)) out_if ();

    parity_frame_receiver #(
        .DATA_WIDTH    (DW),
        .ODD_PARITY    (1'b0),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_bit       (in_bit),
        .in_bit_valid (in_bit_valid),
        .clr_count    (clr_count),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .err_count    (err_count),
        .out_if       (out_if)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_err_cnt = 0;
    int   n_delivered = 0;
    int   n_ferr_seen = 0;
    int   n_ovf_seen = 0;
    int   exp_ferr = 0;
    int   exp_ovf = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rules: even parity expects parity bit == XOR of data bits.
    function automatic logic good_parity(input logic [7:0] d);
        return ^d;
    endfunction

    function automatic void model_push_err();
        if (model_err_cnt < 255) model_err_cnt++;
    endfunction

    // Pulse counting and delivery checking, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (frame_err === 1'b1) n_ferr_seen++;
        if (overflow === 1'b1) n_ovf_seen++;
        if (mon_en && out_if.out_valid === 1'b1 && out_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'(out_if.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", 32'(out_if.out_data), 32'(e.data));
                chk("rx_perr", 32'(out_if.out_parity_err), 32'(e.err));
                n_delivered++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap_pct);
        int g = 0;
        while (gap_pct > 0 && g < 8 && $urandom_range(99) < gap_pct) begin
            in_bit_valid = 1'b0;
            in_bit       = 1'($urandom_range(1));
            tick();
            g++;
        end
        in_bit       = b;
        in_bit_valid = 1'b1;
        tick();
        in_bit_valid = 1'b0;
    endtask

    task automatic send_head(input logic [7:0] d, input logic p, input int gap_pct);
        send_bit(1'b0, gap_pct);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap_pct);
        send_bit(p, gap_pct);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int gap_pct);
        send_head(d, p, gap_pct);
        send_bit(stop, gap_pct);
    endtask

    task automatic drain();
        out_if.out_ready = 1'b1;
        tick();
        out_if.out_ready = 1'b0;
        chk("drain_empty", 32'(out_if.out_valid), 32'd0);
    endtask

    initial begin
        int base;
        int waited;
        logic [7:0] d;

        rst              = 1'b1;
        in_bit           = 1'b1;
        in_bit_valid     = 1'b0;
        clr_count        = 1'b0;
        out_if.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_if.out_valid), 32'd0);
        chk("rst_data", 32'(out_if.out_data), 32'd0);
        chk("rst_perr", 32'(out_if.out_parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        rst = 1'b0;
        tick();

        // Clean frame, contiguous bits, one-cycle latency after stop.
        send_head(8'hA5, good_parity(8'hA5), 0);
        chk("a5_valid_before_stop", 32'(out_if.out_valid), 32'd0);
        send_bit(1'b1, 0);
        chk("a5_valid", 32'(out_if.out_valid), 32'd1);
        chk("a5_data", 32'(out_if.out_data), 32'hA5);
        chk("a5_perr", 32'(out_if.out_parity_err), 32'd0);
        tick();
        chk("a5_stable", 32'(out_if.out_data), 32'hA5);
        drain();

        // Parity error frames and counter saturation.
        send_frame(8'h01, 1'b0, 1'b1, 0);
        model_push_err();
        chk("p01_perr", 32'(out_if.out_parity_err), 32'd1);
        chk("p01_errcnt", 32'(err_count), 32'(model_err_cnt));
        drain();
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 299; i++) begin
            send_frame(8'h01, 1'b0, 1'b1, 0);
            model_push_err();
        end
        tick();
        out_if.out_ready = 1'b0;
        chk("errcnt_sat", 32'(err_count), 32'(model_err_cnt));
        chk("sat_empty", 32'(out_if.out_valid), 32'd0);

        // Clear, then bad stop bit.
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        model_err_cnt = 0;
        chk("clr", 32'(err_count), 32'(model_err_cnt));
        send_frame(8'h01, 1'b0, 1'b0, 0);
        exp_ferr++;
        chk("ferr_pulse", 32'(frame_err), 32'd1);
        chk("ferr_no_valid", 32'(out_if.out_valid), 32'd0);
        chk("ferr_errcnt", 32'(err_count), 32'(model_err_cnt));
        tick();
        chk("ferr_one_cycle", 32'(frame_err), 32'd0);

        // Backpressure: second frame dropped, then same-cycle pop+push.
        send_frame(8'h11, good_parity(8'h11), 1'b1, 0);
        chk("bp_11_valid", 32'(out_if.out_valid), 32'd1);
        send_frame(8'h22, good_parity(8'h22), 1'b1, 0);
        exp_ovf++;
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_hold", 32'(out_if.out_data), 32'h11);
        tick();
        chk("ovf_one_cycle", 32'(overflow), 32'd0);
        send_head(8'h22, good_parity(8'h22), 0);
        out_if.out_ready = 1'b1;
        send_bit(1'b1, 0);
        out_if.out_ready = 1'b0;
        chk("swap_no_ovf", 32'(overflow), 32'd0);
        chk("swap_valid", 32'(out_if.out_valid), 32'd1);
        chk("swap_data", 32'(out_if.out_data), 32'h22);
        drain();

        // Random bytes with random valid gaps, consumer always ready.
        mon_en           = 1'b1;
        out_if.out_ready = 1'b1;
        base             = n_delivered;
        for (int i = 0; i < 100; i++) begin
            d = 8'($urandom);
            exp_q.push_back('{data: d, err: 1'b0});
            send_frame(d, good_parity(d), 1'b1, 50);
        end
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            tick();
            waited++;
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_count", 32'(n_delivered - base), 32'd100);
        chk("rand_errcnt", 32'(err_count), 32'(model_err_cnt));

        // Reset mid-frame discards partial frame and the error count.
        base = n_delivered;
        exp_q.push_back('{data: 8'h01, err: 1'b1});
        send_frame(8'h01, 1'b0, 1'b1, 0);
        model_push_err();
        chk("pre_rst_errcnt", 32'(err_count), 32'(model_err_cnt));
        tick();
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_err_cnt = 0;
        chk("midrst_errcnt", 32'(err_count), 32'(model_err_cnt));
        exp_q.push_back('{data: 8'h3C, err: 1'b0});
        send_frame(8'h3C, good_parity(8'h3C), 1'b1, 0);
        repeat (3) tick();
        chk("midrst_delivered", 32'(n_delivered - base), 32'd2);
        chk("midrst_drained", 32'(exp_q.size()), 32'd0);

        // Clear coincident with a parity-error load.
        exp_q.push_back('{data: 8'h01, err: 1'b1});
        send_head(8'h01, 1'b0, 0);
        clr_count = 1'b1;
        send_bit(1'b1, 0);
        clr_count = 1'b0;
        chk("clr_wins", 32'(err_count), 32'd0);
        repeat (3) tick();
        chk("clr_hold", 32'(err_count), 32'd0);

        chk("ferr_total", 32'(n_ferr_seen), 32'(exp_ferr));
        chk("ovf_total", 32'(n_ovf_seen), 32'(exp_ovf));
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
